// File: rtl/simon_pkg.sv
// ---------------------------------------------------------------------------
// simon_pkg
// Shared definitions for the Simon game engine:
//   - state_e     : FSM state encoding, also driven out on the debug port
//   - LFSR_SEED   : value loaded into the LFSR on reset
//   - LFSR_TAPS   : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   - onehot()    : button index -> one-hot LED pattern (up to 8 buttons)
// ---------------------------------------------------------------------------
package simon_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_RELEASE  = 3'd5,
        S_ERROR    = 3'd6,
        S_WIN      = 3'd7
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Indices at or above num_btn produce an all-zero pattern.
    function automatic logic [7:0] onehot(input logic [2:0] idx, input int num_btn);
        logic [7:0] v;
        v = '0;
        if (int'(idx) < num_btn) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// ---------------------------------------------------------------------------
// simon_lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), one step per clock.
// Ports:
//   clk_i  : clock
//   rst_ni : synchronous active-low reset, loads LFSR_SEED
//   rnd_o  : low OUT_W bits of the LFSR state
// ---------------------------------------------------------------------------
module simon_lfsr16
    import simon_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [OUT_W-1:0] rnd_o
);

    logic [15:0] lfsr_q;
    logic        fb;

    assign fb = ^(lfsr_q & LFSR_TAPS);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], fb};
        end
    end

    assign rnd_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/simon_core_param.sv
// ---------------------------------------------------------------------------
// simon_core_param
// Parametrised Simon game engine: random sequence generation, timed
// playback, player-input checking, input timeout, win/lose detection.
// Everything runs on clk; game timing uses a one-cycle tick enable.
// Ports:
//   clk       : system clock
//   reset     : synchronous active-low reset
//   btn       : debounced button levels, 1 = pressed
//   led       : game LEDs, 1 = lit
//   error_led : set in ERROR, held until the next game start
//   win_led   : set in WIN, held until the next game start
//   level     : current sequence length / final score
//   state     : FSM state encoding (debug display)
//   busy      : high whenever the FSM is not in IDLE or WAIT_IN
// Optional feature macro: SIMON_SPEEDUP_EN -- once level > MAX_LEN/2 the
// playback on/off phases shrink to ceil(N/2) ticks (minimum 1).
// led/error_led/win_led/busy are registered from the current state, so they
// follow a state change by one clock.
// ---------------------------------------------------------------------------
module simon_core_param
    import simon_pkg::*;
#(
    parameter int NUM_BTN       = 4,
    parameter int MAX_LEN       = 16,
    parameter int TICK_CYCLES   = 25_000_000,
    parameter int ON_TICKS      = 2,
    parameter int OFF_TICKS     = 1,
    parameter int TIMEOUT_TICKS = 10,
    parameter int ERR_TICKS     = 4,
    localparam int CW = $clog2(NUM_BTN),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] led,
    output logic               error_led,
    output logic               win_led,
    output logic [LW-1:0]      level,
    output logic [2:0]         state,
    output logic               busy
);

    localparam int AW    = $clog2(MAX_LEN);
    localparam int PW    = $clog2(TICK_CYCLES);
    localparam int TM_A  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TM_B  = (TIMEOUT_TICKS > ERR_TICKS) ? TIMEOUT_TICKS : ERR_TICKS;
    localparam int TMAX  = (TM_A > TM_B) ? TM_A : TM_B;
    localparam int TW    = $clog2(TMAX + 1);

    state_e             state_q;
    logic [PW-1:0]      presc_q;
    logic [TW-1:0]      tcnt_q;
    logic [LW-1:0]      level_q;
    logic [AW-1:0]      step_q;
    logic [AW-1:0]      idx_q;
    logic               btn_prev_q;
    logic [NUM_BTN-1:0] led_q;
    logic               err_q;
    logic               win_q;
    logic               busy_q;
    logic               blink_q;
    logic [CW-1:0]      seq_q [MAX_LEN];

    logic               tick;
    logic               btn_any;
    logic               press;
    logic               press_one;
    logic [CW-1:0]      press_idx;
    logic [3:0]         n_set;
    logic [CW-1:0]      lfsr_bits;
    logic [CW-1:0]      rnd;
    logic [TW-1:0]      phase_len;
    logic               phase_end;
    logic [LW-1:0]      last;
    logic [7:0]         show_oh;
    logic               unused_oh;

    simon_lfsr16 #(.OUT_W(CW)) u_lfsr (
        .clk_i  (clk),
        .rst_ni (reset),
        .rnd_o  (lfsr_bits)
    );

    // Fold an out-of-range LFSR slice back into 0..NUM_BTN-1.
    always_comb begin
        rnd = lfsr_bits;
        if ({1'b0, lfsr_bits} >= (CW+1)'(NUM_BTN)) begin
            rnd = lfsr_bits - CW'(NUM_BTN);
        end
    end

    // Pressed index is the highest set bit; press_one flags a clean single press.
    always_comb begin
        press_idx = '0;
        n_set     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (btn[i]) begin
                press_idx = CW'(i);
                n_set     = n_set + 4'd1;
            end
        end
    end

    assign btn_any   = |btn;
    assign press     = btn_any & ~btn_prev_q;
    assign press_one = (n_set == 4'd1);
    assign tick      = (presc_q == PW'(TICK_CYCLES - 1));
    assign last      = level_q - LW'(1);
    assign show_oh   = onehot(3'(seq_q[step_q]), NUM_BTN);
    assign unused_oh = ^show_oh;

`ifdef SIMON_SPEEDUP_EN
    localparam int ON_FAST  = ((ON_TICKS + 1) / 2 < 1) ? 1 : (ON_TICKS + 1) / 2;
    localparam int OFF_FAST = ((OFF_TICKS + 1) / 2 < 1) ? 1 : (OFF_TICKS + 1) / 2;
    logic fast;
    assign fast = (level_q > LW'(MAX_LEN / 2));

    always_comb begin
        phase_len = TW'(TIMEOUT_TICKS);
        case (state_q)
            S_SHOW_ON:  phase_len = fast ? TW'(ON_FAST) : TW'(ON_TICKS);
            S_SHOW_OFF: phase_len = fast ? TW'(OFF_FAST) : TW'(OFF_TICKS);
            S_ERROR:    phase_len = TW'(ERR_TICKS);
            default:    phase_len = TW'(TIMEOUT_TICKS);
        endcase
    end
`else
    always_comb begin
        phase_len = TW'(TIMEOUT_TICKS);
        case (state_q)
            S_SHOW_ON:  phase_len = TW'(ON_TICKS);
            S_SHOW_OFF: phase_len = TW'(OFF_TICKS);
            S_ERROR:    phase_len = TW'(ERR_TICKS);
            default:    phase_len = TW'(TIMEOUT_TICKS);
        endcase
    end
`endif

    // tcnt_q counts ticks already seen in the phase; the Nth tick ends it.
    assign phase_end = tick && (tcnt_q == phase_len - TW'(1));

    // Sequence contents need no reset: every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (reset && state_q == S_GEN) begin
            seq_q[level_q[AW-1:0]] <= rnd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            tcnt_q     <= '0;
            level_q    <= '0;
            step_q     <= '0;
            idx_q      <= '0;
            btn_prev_q <= 1'b0;
            led_q      <= '0;
            err_q      <= 1'b0;
            win_q      <= 1'b0;
            busy_q     <= 1'b0;
            blink_q    <= 1'b1;
        end else begin
            btn_prev_q <= btn_any;
            presc_q    <= tick ? '0 : presc_q + PW'(1);

            // Registered outputs, derived from the state held this cycle.
            busy_q  <= !(state_q == S_IDLE || state_q == S_WAIT_IN);
            blink_q <= (state_q == S_WIN) ? (blink_q ^ tick) : 1'b1;
            case (state_q)
                S_GEN: begin
                    led_q <= '0;
                    err_q <= 1'b0;
                    win_q <= 1'b0;
                end
                S_SHOW_ON:            led_q <= show_oh[NUM_BTN-1:0];
                S_WAIT_IN, S_RELEASE: led_q <= btn;
                S_ERROR: begin
                    led_q <= '1;
                    err_q <= 1'b1;
                end
                S_WIN: begin
                    led_q <= {NUM_BTN{blink_q}};
                    win_q <= 1'b1;
                end
                default:              led_q <= '0;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (press) begin
                        level_q <= '0;
                        state_q <= S_GEN;
                    end
                end
                S_GEN: begin
                    level_q <= level_q + LW'(1);
                    step_q  <= '0;
                    tcnt_q  <= '0;
                    state_q <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (phase_end) begin
                        tcnt_q  <= '0;
                        state_q <= S_SHOW_OFF;
                    end else if (tick) begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_SHOW_OFF: begin
                    if (phase_end) begin
                        tcnt_q <= '0;
                        if (LW'(step_q) == last) begin
                            idx_q   <= '0;
                            state_q <= S_WAIT_IN;
                        end else begin
                            step_q  <= step_q + AW'(1);
                            state_q <= S_SHOW_ON;
                        end
                    end else if (tick) begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_WAIT_IN: begin
                    // A press in the same cycle as a tick takes priority.
                    if (press) begin
                        tcnt_q <= '0;
                        if (press_one && press_idx == seq_q[idx_q]) begin
                            if (LW'(idx_q) == last) begin
                                state_q <= S_RELEASE;
                            end else begin
                                idx_q <= idx_q + AW'(1);
                            end
                        end else begin
                            state_q <= S_ERROR;
                        end
                    end else if (phase_end) begin
                        tcnt_q  <= '0;
                        state_q <= S_ERROR;
                    end else if (tick) begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_RELEASE: begin
                    if (!btn_any) begin
                        state_q <= (level_q == LW'(MAX_LEN)) ? S_WIN : S_GEN;
                    end
                end
                S_ERROR: begin
                    if (phase_end) begin
                        tcnt_q  <= '0;
                        state_q <= S_IDLE;
                    end else if (tick) begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_WIN: begin
                    if (press) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign led       = led_q;
    assign error_led = err_q;
    assign win_led   = win_q;
    assign level     = level_q;
    assign state     = state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_simon_core_param.sv
// ---------------------------------------------------------------------------
// tb_simon_core_param
// Directed bench for simon_core_param with NUM_BTN=4, MAX_LEN=3,
// TICK_CYCLES=4, ON=2, OFF=1, TIMEOUT=5, ERR=2. The played-back sequence is
// learned from the LEDs and kept in exp_q; later rounds must replay it.
// ---------------------------------------------------------------------------
module tb_simon_core_param;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GEN     = 3'd1;
    localparam logic [2:0] ST_SHOW_ON = 3'd2;
    localparam logic [2:0] ST_WAIT_IN = 3'd4;
    localparam logic [2:0] ST_ERROR   = 3'd6;
    localparam logic [2:0] ST_WIN     = 3'd7;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] led;
    logic       error_led;
    logic       win_led;
    logic [1:0] level;
    logic [2:0] state;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    simon_core_param #(
        .NUM_BTN(4), .MAX_LEN(3), .TICK_CYCLES(4), .ON_TICKS(2),
        .OFF_TICKS(1), .TIMEOUT_TICKS(5), .ERR_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .led(led),
        .error_led(error_led), .win_led(win_led), .level(level),
        .state(state), .busy(busy)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, state, s);
    endtask

    // Press from IDLE: GEN for one cycle, then SHOW_ON with level 1.
    task automatic start_game();
        exp_q.delete();
        btn = 4'b0001;
        @(negedge clk);
        check("start_gen", state, ST_GEN);
        btn = 4'b0000;
        @(negedge clk);
        check("start_show", state, ST_SHOW_ON);
        check("start_level", level, 1);
    endtask

    // Watch one playback round of lvl flashes, ending one cycle into WAIT_IN.
    task automatic capture_round(input int lvl);
        for (int k = 0; k < lvl; k++) begin
            int n;
            int dur;
            int idx;
            logic [3:0] v;
            n = 0;
            while (led == 4'b0000 && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("flash_seen", (led != 4'b0000), 1);
            check("flash_onehot", $onehot(led), 1);
            if (k == 0) check("busy_show", busy, 1);
            v   = led;
            idx = 0;
            for (int b = 0; b < 4; b++) if (v[b]) idx = b;
            dur = 0;
            while (led == v && dur < 20) begin
                @(negedge clk);
                dur++;
            end
            check("flash_len", (dur >= 5 && dur <= 8), 1);
            if (k < exp_q.size()) check("replay", idx, exp_q[k]);
            else exp_q.push_back(2'(idx));
        end
        wait_state(ST_WAIT_IN, 20, "enter_wait");
        check("round_level", level, lvl);
        @(negedge clk);
        check("busy_wait", busy, 0);
    endtask

    task automatic echo_round(input int lvl);
        for (int k = 0; k < lvl; k++) begin
            logic [3:0] mask;
            mask = 4'b0001 << exp_q[k];
            btn  = mask;
            @(negedge clk);
            check("echo_led", led, mask);
            btn = 4'b0000;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int bad;
        logic [3:0] v;
        reset = 1'b0;
        btn   = 4'b0000;

        // reset, with a button pulse while held
        @(negedge clk);
        btn = 4'b0001;
        @(negedge clk);
        btn = 4'b0000;
        @(negedge clk);
        check("rst_led", led, 0);
        check("rst_err", error_led, 0);
        check("rst_win", win_led, 0);
        check("rst_level", level, 0);
        check("rst_state", state, ST_IDLE);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", state, ST_IDLE);

        // full game to WIN
        start_game();
        for (int lvl = 1; lvl <= 3; lvl++) begin
            capture_round(lvl);
            echo_round(lvl);
        end
        wait_state(ST_WIN, 40, "enter_win");
        check("win_level", level, 3);
        @(negedge clk);
        check("win_led_on", win_led, 1);
        check("win_pattern", (led == 4'b0000 || led == 4'b1111), 1);
        v = led;
        n = 0;
        while (led == v && n < 12) begin
            @(negedge clk);
            n++;
        end
        for (int r = 0; r < 2; r++) begin
            v = led;
            n = 0;
            while (led == v && n < 12) begin
                @(negedge clk);
                n++;
            end
            check("win_toggle", n, 4);
        end
        btn = 4'b0001;
        @(negedge clk);
        check("win_to_idle", state, ST_IDLE);
        btn = 4'b0000;
        @(negedge clk);
        check("win_led_hold", win_led, 1);
        check("win_level_hold", level, 3);

        // mismatch at level 1
        start_game();
        check("win_cleared", win_led, 0);
        capture_round(1);
        bad = (int'(exp_q[0]) + 1) % 4;
        btn = 4'b0001 << bad;
        @(negedge clk);
        check("mismatch_err", state, ST_ERROR);
        btn = 4'b0000;
        @(negedge clk);
        check("err_led_on", error_led, 1);
        check("err_led_all", led, 4'b1111);
        n = 2;
        while (state == ST_ERROR && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("err_to_idle", state, ST_IDLE);
        check("err_len", (n >= 6 && n <= 9), 1);
        check("err_level_hold", level, 1);
        @(negedge clk);
        check("err_led_hold", error_led, 1);

        // timeout, with a press restarting the count
        start_game();
        check("err_cleared", error_led, 0);
        capture_round(1);
        echo_round(1);
        capture_round(2);
        repeat (11) @(negedge clk);
        btn = 4'b0001 << exp_q[0];
        @(negedge clk);
        check("restart_pre", state, ST_WAIT_IN);
        btn = 4'b0000;
        n = 1;
        repeat (13) begin
            @(negedge clk);
            n++;
        end
        check("restart_hold", state, ST_WAIT_IN);
        while (state != ST_ERROR && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_err", state, ST_ERROR);
        check("timeout_len", (n >= 18 && n <= 21), 1);
        wait_state(ST_IDLE, 20, "timeout_idle");

        // two buttons at once
        start_game();
        capture_round(1);
        btn = 4'b0011;
        @(negedge clk);
        check("multi_err", state, ST_ERROR);
        btn = 4'b0000;
        wait_state(ST_IDLE, 20, "multi_idle");

        // reset during playback
        start_game();
        @(negedge clk);
        check("pre_reset_lit", (led != 4'b0000), 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_led", led, 0);
        check("mid_rst_state", state, ST_IDLE);
        check("mid_rst_level", level, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", error_led, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
